fc_neuron_acc: RTL and testbench

//  Upstream feeder of the sigmoid stage in the fully-connected layer: accumulates
//  N_IN signed fixed-point data*weight products plus a bias for one neuron,

---
 rtl/fc_neuron_acc.sv | 168 ++++++++++++++++
 tb/tb_fc_neuron_acc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_acc.sv
// -----------------------------------------------------------------------------
// fc_neuron_acc
//   Multiply-accumulate front end for one neuron of a fully-connected layer.
//   A start pulse loads the bias, pre-shifted into the accumulator's fixed-point
//   format. The caller then streams N_IN data/weight beats on in_valid, and
//   each beat adds the full-precision signed product to the accumulator. After
//   the last beat, one OUT cycle drops the FRAC_W fractional bits, which floors
//   the sum toward -inf. It then registers the OUT_W-bit result with an
//   overflow flag and pulses out_ena for one cycle. The result feeds the
//   sigmoid stage (ena / sigmoid_in).
//
//   Optional feature macro: FC_ACC_SAT_EN
//     defined   -> out_data saturates to the OUT_W signed range on overflow
//     undefined -> out_data is the low OUT_W bits of the sum (two's-complement wrap)
//     ovf is computed identically in both builds.
//
//   Assumes ACC_W - FRAC_W >= OUT_W and ACC_W >= DATA_W + WEIGHT_W,
//   ACC_W >= DATA_W + FRAC_W.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a neuron (sampled only in IDLE)
//   bias       in   signed bias, sampled with start
//   in_valid   in   in_data/in_weight beat valid (counted only in ACC)
//   in_data    in   signed activation
//   in_weight  in   signed weight
//   busy       out  high while accumulating or producing the output
//   out_ena    out  one-cycle pulse, out_data/ovf valid
//   out_data   out  signed rescaled sum, held until the next out_ena
//   ovf        out  rescaled sum outside the OUT_W signed range
// -----------------------------------------------------------------------------
module fc_neuron_acc #(
    parameter int DATA_W   = 16,
    parameter int WEIGHT_W = 16,
    parameter int FRAC_W   = 8,
    parameter int N_IN     = 64,
    parameter int ACC_W    = 48,
    parameter int OUT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic signed [DATA_W-1:0]   bias,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic signed [WEIGHT_W-1:0] in_weight,
    output logic                       busy,
    output logic                       out_ena,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       ovf
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int SUM_W  = ACC_W - FRAC_W;
    localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_q,    state_d;
    logic signed [ACC_W-1:0]  acc_q,      acc_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic                     out_ena_q,  out_ena_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic                     ovf_q,      ovf_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [SUM_W-1:0]  sum_s;
    logic [SUM_W-OUT_W:0]     sum_hi;
    logic                     sum_ovf;
    logic signed [OUT_W-1:0]  sum_conv;

    // Full double-precision product, sign-extended into the accumulator.
    assign prod     = in_data * in_weight;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Bias shares FRAC_W with the data, so it must be scaled up to the
    // product format (2*FRAC_W fractional bits) before it seeds the sum.
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

    // Dropping the low FRAC_W bits of a two's-complement value is an
    // arithmetic shift, i.e. a floor toward -inf.
    assign sum_s = acc_q[ACC_W-1:FRAC_W];

    // The value fits in OUT_W signed bits iff every bit from the OUT_W sign
    // position upward is a copy of the same sign.
    assign sum_hi  = sum_s[SUM_W-1:OUT_W-1];
    assign sum_ovf = !((&sum_hi) || (~|sum_hi));

`ifdef FC_ACC_SAT_EN
    always_comb begin
        sum_conv = sum_s[OUT_W-1:0];
        if (sum_ovf) begin
            sum_conv = sum_s[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign sum_conv = sum_s[OUT_W-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_ena_d  = 1'b0;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                out_data_d = sum_conv;
                ovf_d      = sum_ovf;
                out_ena_d  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_ena_q  <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_ena_q  <= out_ena_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign out_ena  = out_ena_q;
    assign out_data = out_data_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fc_neuron_acc.sv
// -----------------------------------------------------------------------------
// tb_fc_neuron_acc
//   Scoreboard bench for fc_neuron_acc. Two instances share all inputs: one
//   with default OUT_W=32 and one with OUT_W=16 for the overflow behaviour.
//   Expected results are computed from a 64-bit reference sum when a neuron's
//   last beat is driven, then popped when out_ena is seen. Expected overflow
//   data follows the FC_ACC_SAT_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_fc_neuron_acc;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [15:0] bias;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic signed [15:0] in_weight;

    logic               busy,    busy16;
    logic               out_ena, out_ena16;
    logic signed [31:0] out_data;
    logic signed [15:0] out_data16;
    logic               ovf,     ovf16;

    always #5 clk = ~clk;

    fc_neuron_acc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .in_weight(in_weight),
        .busy(busy), .out_ena(out_ena), .out_data(out_data), .ovf(ovf)
    );

    fc_neuron_acc #(.OUT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_data(in_data), .in_weight(in_weight),
        .busy(busy16), .out_ena(out_ena16), .out_data(out_data16), .ovf(ovf16)
    );

    typedef struct {
        longint e32;
        bit     o32;
        longint e16;
        bit     o16;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     ena_count = 0;
    longint td[64];
    longint tw[64];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint b);
        exp_t        e;
        longint      sum;
        longint      s;
        logic [63:0] sv;
        sum = b * 256;
        for (int i = 0; i < 64; i++) sum += td[i] * tw[i];
        s  = sum >>> 8;
        sv = s;
        e.e32 = longint'($signed(sv[31:0]));
        e.o32 = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.o16 = (s > 64'sd32767) || (s < -64'sd32768);
`ifdef FC_ACC_SAT_EN
        if (e.o16) e.e16 = (s < 0) ? -64'sd32768 : 64'sd32767;
        else       e.e16 = longint'($signed(sv[15:0]));
`else
        e.e16 = longint'($signed(sv[15:0]));
`endif
        return e;
    endfunction

    // Scoreboard consumer: one pop per out_ena pulse.
    always @(negedge clk) begin
        if (out_ena) begin
            exp_t e;
            ena_count++;
            check_eq("ena16_align", longint'(out_ena16), 1);
            if (sb.size() == 0) begin
                check_eq("unexpected_out_ena", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("out_data32", longint'(out_data), e.e32);
                check_eq("ovf32", longint'(ovf), longint'(e.o32));
                check_eq("out_data16", longint'(out_data16), e.e16);
                check_eq("ovf16", longint'(ovf16), longint'(e.o16));
                $display("neuron done: out_data=%0d ovf=%0d out16=%0d ovf16=%0d",
                         out_data, ovf, out_data16, ovf16);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input longint b);
        start = 1'b1;
        bias  = 16'(b);
        tick();
        start = 1'b0;
        bias  = '0;
    endtask

    // Drives one full neuron from td/tw; gaps adds idle cycles carrying
    // spurious start pulses and junk data with in_valid low.
    task automatic drive_neuron(input longint b, input bit gaps);
        do_start(b);
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid  = 1'b0;
                    start     = 1'($urandom_range(0, 1));
                    in_data   = 16'($urandom);
                    in_weight = 16'($urandom);
                    tick();
                end
                start = 1'b0;
            end
            in_valid  = 1'b1;
            in_data   = 16'(td[i]);
            in_weight = 16'(tw[i]);
            if (i == 63) sb.push_back(model(b));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check_eq("drain_timeout", longint'(sb.size()), 0);
        tick();
    endtask

    task automatic fill(input longint d, input longint w);
        for (int i = 0; i < 64; i++) begin
            td[i] = d;
            tw[i] = w;
        end
    endtask

    initial begin
        int ena_before;
        rst_n = 1'b0; start = 1'b0; bias = '0;
        in_valid = 1'b0; in_data = '0; in_weight = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", longint'(busy), 0);
        check_eq("rst_out_ena", longint'(out_ena), 0);
        check_eq("rst_out_data", longint'(out_data), 0);
        check_eq("rst_ovf", longint'(ovf), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Case 1: basic sum plus exact latency and pulse width.
        fill(256, 256);
        drive_neuron(0, 1'b0);
        @(negedge clk);
        check_eq("lat_out_state_ena", longint'(out_ena), 0);
        check_eq("lat_out_state_busy", longint'(busy), 1);
        @(negedge clk);
        check_eq("lat_ena_high", longint'(out_ena), 1);
        check_eq("lat_busy_low", longint'(busy), 0);
        check_eq("case1_value", longint'(out_data), 16384);
        @(negedge clk);
        check_eq("ena_one_cycle", longint'(out_ena), 0);
        check_eq("data_hold", longint'(out_data), 16384);
        wait_drain();

        // Case 2: negative bias and products.
        fill(-256, 256);
        drive_neuron(-512, 1'b0);
        wait_drain();

        // Case 3: floor rounding, second neuron started in the out_ena cycle.
        ena_before = ena_count;
        fill(0, 0);
        td[0] = 1; tw[0] = 1;
        drive_neuron(0, 1'b0);
        tick();
        td[0] = -1;
        drive_neuron(0, 1'b0);
        wait_drain();
        check_eq("b2b_ena_count", longint'(ena_count - ena_before), 2);

        // Case 4: overflow of the 16-bit instance.
        fill(32767, 32767);
        drive_neuron(0, 1'b0);
        wait_drain();

        // Case 5: gaps, stray starts, in_valid outside ACC.
        ena_before = ena_count;
        fill(256, 256);
        in_valid = 1'b1; in_data = 16'sd1000; in_weight = 16'sd1000;
        repeat (3) tick();
        in_valid = 1'b0;
        drive_neuron(0, 1'b1);
        in_valid = 1'b1; in_data = 16'sd500; in_weight = 16'sd500;
        repeat (2) tick();
        in_valid = 1'b0;
        wait_drain();
        check_eq("gap_ena_count", longint'(ena_count - ena_before), 1);

        // Case 6: reset after 30 beats, then case 2 again.
        ena_before = ena_count;
        fill(-256, 256);
        do_start(-512);
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; in_data = 16'sd300; in_weight = 16'sd300;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_busy", longint'(busy), 0);
        check_eq("midrst_out_data", longint'(out_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        check_eq("midrst_no_ena", longint'(ena_count - ena_before), 0);
        drive_neuron(-512, 1'b0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
